imm_exec_stage: RTL and testbench
=================================

Name: imm_exec_stage

Overview:
- Execute/writeback stage directly downstream of the I-type decoder.
- Accepts decoded fields (rs1, rd, 12-bit imm, 5-bit alu_control) through a valid/ready handshake and reads rs1 from the register file.
- Computes the I-type ALU result. Non-shift ops take one execute cycle; SLLI/SRLI/SRAI use a serial one-bit-per-cycle shifter.
- Issues a single-cycle writeback to the register file.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the in-flight op.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_rs1  input  5  source register index.
- in_rd  input  5  destination register index.
- in_imm  input  12  raw immediate, imm[11:0].
- in_alu_control  input  5  op code from the shared ALU-code constants.
- rf_raddr  output  5  register file read address; combinationally equal to in_rs1.
- rf_rdata  input  XLEN  register file read data; combinational, same cycle.
- wb_valid  output  1  writeback pulse.
- wb_en  output  1  wb_valid && (wb_rd != 0).
- wb_rd  output  5  writeback destination.
- wb_data  output  XLEN  writeback value.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, busy=0.
  - All captured fields and the shift counter are cleared.
  - Any in-flight op is discarded, with no writeback.
- Handshake:
  - in_ready = (state==IDLE || state==WB) && !flush.
  - Accept occurs on a cycle where in_valid && in_ready.
  - On accept, register rd, imm, alu_control and rf_rdata (the rs1 value).
- States:
  - IDLE: on accept -> EXEC.
  - EXEC:
    - Non-shift op: compute result into result_q -> WB.
    - Shift op with shamt=imm[4:0]==0: result_q=rs1 value -> WB.
    - Shift op with shamt!=0: load shift_q=rs1 value and cnt=shamt -> SHIFT.
  - SHIFT: each cycle shift shift_q by 1 and decrement cnt. When cnt==1 at the edge, result_q=shifted value -> WB.
  - WB:
    - wb_valid=1 for exactly this cycle; wb_rd, wb_data and wb_en driven from the registered values.
    - Accept in the same cycle -> EXEC; otherwise -> IDLE.
- Latency (accept in cycle N):
  - Non-shift op: wb_valid in cycle N+2.
  - Shift op: wb_valid in cycle N+2+shamt.
  - Peak throughput: 1 instruction per 2 cycles.
- Arithmetic:
  - sext = sign-extended imm[11:0] to XLEN.
  - ADDI: rs1 + sext, modulo 2^32.
  - SLTI: signed(rs1) < signed(sext) ? 1 : 0.
  - SLTIU: rs1 < sext, compared unsigned (sext still sign-extended).
  - XORI/ORI/ANDI: bitwise with sext.
  - SLLI: shift left, zero fill. SRLI: shift right, zero fill. SRAI: shift right, fill with bit 31.
  - Any other alu_control code executes as ADDI.
- Flush:
  - flush=1 in EXEC/SHIFT/WB: state -> IDLE at the next edge.
  - If flush is high in the WB cycle, wb_valid, wb_en and wb_data are forced to 0 combinationally.
  - flush with in_valid: flush wins, no accept.
  - flush in IDLE: no effect.
- Destination x0: wb_valid still pulses and wb_en=0.
- in_valid while not ready: no capture. Upstream holds its fields until accepted.

Decomposition:
- ALU op codes (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI) come from the shared ALU-code constants also used by the decoder. The state enum (IDLE, EXEC, SHIFT, WB) goes in the shared RISC-V package.
- One sub-module: imm_alu_comb, the combinational non-shift ALU (inputs: rs1 value, sext, alu_control; output: result).
- Serial shifter and FSM stay in imm_exec_stage.

Test Plan:
- ADDI: rf_rdata=32'h0000_0005, imm=12'hFFF, rd=3, accepted cycle N -> wb_valid at N+2, wb_data=32'h0000_0004, wb_rd=3, wb_en=1.
- SLTIU vs SLTI:
  - rf_rdata=32'h0000_0001, imm=12'h800, SLTIU -> wb_data=1.
  - Same operands with SLTI -> wb_data=0.
- SRAI: rf_rdata=32'h8000_0000, imm=12'h404 (shamt 4) -> wb_valid exactly at N+6, wb_data=32'hF800_0000. busy high N+1..N+6.
- SLLI shamt=0 with rd=0: rf_rdata=32'hDEAD_BEEF -> wb at N+2, wb_data=32'hDEAD_BEEF, wb_en=0.
- Back-to-back with flush:
  - ORI accepted in its predecessor's WB cycle -> second wb_valid 2 cycles after the first.
  - flush asserted in SHIFT -> no wb_valid, IDLE next cycle, in_ready=1.
- Reset mid-SHIFT: rst_n pulled low asynchronously -> wb_valid=0 and busy=0 immediately. After release, no stale writeback, and a new ADDI completes at N+2.

Source files
------------

// File: rtl/imm_exec_stage_pkg.sv
// rtl/imm_exec_stage_pkg.sv - shared ALU codes, stage states and helpers for the I-type execute stage
package imm_exec_stage_pkg;

    // ALU operation codes shared with the I-type decoder
    localparam logic [4:0] ALU_ADDI  = 5'd0;
    localparam logic [4:0] ALU_SLTI  = 5'd1;
    localparam logic [4:0] ALU_SLTIU = 5'd2;
    localparam logic [4:0] ALU_XORI  = 5'd3;
    localparam logic [4:0] ALU_ORI   = 5'd4;
    localparam logic [4:0] ALU_ANDI  = 5'd5;
    localparam logic [4:0] ALU_SLLI  = 5'd6;
    localparam logic [4:0] ALU_SRLI  = 5'd7;
    localparam logic [4:0] ALU_SRAI  = 5'd8;

    // Execute stage states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    // Shift ops go through the serial shifter instead of the one-cycle ALU
    function automatic logic is_shift_op(input logic [4:0] code);
        return (code == ALU_SLLI) || (code == ALU_SRLI) || (code == ALU_SRAI);
    endfunction

    // Sign-extend the 12-bit immediate to the 32-bit datapath
    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/imm_alu_comb.sv
// rtl/imm_alu_comb.sv - combinational non-shift I-type ALU
module imm_alu_comb
    import imm_exec_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] sext,
    input  logic [4:0]      alu_control,
    output logic [XLEN-1:0] result
);

    // Select the op result; unknown codes (and shift codes, never used from here) fall back to ADDI
    always_comb begin
        result = rs1 + sext;
        case (alu_control)
            ALU_SLTI:  result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(sext))};
            ALU_SLTIU: result = {{(XLEN-1){1'b0}}, (rs1 < sext)};
            ALU_XORI:  result = rs1 ^ sext;
            ALU_ORI:   result = rs1 | sext;
            ALU_ANDI:  result = rs1 & sext;
            default:   result = rs1 + sext;
        endcase
    end

endmodule

// File: rtl/imm_exec_stage.sv
// rtl/imm_exec_stage.sv - I-type execute/writeback stage with serial shifter
module imm_exec_stage
    import imm_exec_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rd,
    input  logic [11:0]     in_imm,
    input  logic [4:0]      in_alu_control,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            wb_valid,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
);

    logic [1:0]      state_q;
    logic [4:0]      rd_q;
    logic [11:0]     imm_q;
    logic [4:0]      alu_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] shift_q;
    logic [4:0]      cnt_q;

    logic            accept;
    logic [XLEN-1:0] sext;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] shift_next;
    logic [4:0]      shamt;
    logic            wb_live;

    assign rf_raddr = in_rs1;
    assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_WB)) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);

    assign sext  = sext12(imm_q);
    assign shamt = imm_q[4:0];

    // A flush during WB suppresses the pulse and its data in the same cycle
    assign wb_live  = (state_q == ST_WB) && !flush;
    assign wb_valid = wb_live;
    assign wb_en    = wb_live && (rd_q != 5'd0);
    assign wb_rd    = rd_q;
    assign wb_data  = wb_live ? result_q : '0;

    imm_alu_comb #(.XLEN(XLEN)) u_alu (
        .rs1         (rs1_q),
        .sext        (sext),
        .alu_control (alu_q),
        .result      (alu_result)
    );

    // One-bit step of the serial shifter; SRAI replicates the sign bit
    always_comb begin
        shift_next = {shift_q[XLEN-1], shift_q[XLEN-1:1]};
        if (alu_q == ALU_SLLI) begin
            shift_next = {shift_q[XLEN-2:0], 1'b0};
        end else if (alu_q == ALU_SRLI) begin
            shift_next = {1'b0, shift_q[XLEN-1:1]};
        end
    end

    // Stage FSM, operand capture and serial shift datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_q     <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            rs1_q    <= '0;
            result_q <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                rd_q  <= in_rd;
                imm_q <= in_imm;
                alu_q <= in_alu_control;
                rs1_q <= rf_rdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (!is_shift_op(alu_q)) begin
                        result_q <= alu_result;
                        state_q  <= ST_WB;
                    end else if (shamt == 5'd0) begin
                        result_q <= rs1_q;
                        state_q  <= ST_WB;
                    end else begin
                        shift_q <= rs1_q;
                        cnt_q   <= shamt;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        shift_q <= shift_next;
                        cnt_q   <= cnt_q - 5'd1;
                        if (cnt_q == 5'd1) begin
                            result_q <= shift_next;
                            state_q  <= ST_WB;
                        end
                    end
                end
                default: begin
                    state_q <= accept ? ST_EXEC : ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_exec_stage.sv
// tb/tb_imm_exec_stage.sv - directed self-checking bench for imm_exec_stage
module tb_imm_exec_stage;
    import imm_exec_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rd;
    logic [11:0] in_imm;
    logic [4:0]  in_alu_control;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    imm_exec_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1         (in_rs1),
        .in_rd          (in_rd),
        .in_imm         (in_imm),
        .in_alu_control (in_alu_control),
        .rf_raddr       (rf_raddr),
        .rf_rdata       (rf_rdata),
        .wb_valid       (wb_valid),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [11:0] imm,
                         input logic [4:0] rd);
        in_valid       = 1'b1;
        in_alu_control = op;
        rf_rdata       = a;
        in_imm         = imm;
        in_rd          = rd;
        in_rs1         = rd ^ 5'h1f;
    endtask

    // Called at a falling edge; returns at the falling edge of the writeback cycle
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [11:0] imm, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        int k;
        int busy_low;
        bit got;
        drive(op, a, imm, rd);
        #1;
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_raddr"}, {27'd0, rf_raddr}, {27'd0, rd ^ 5'h1f});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rf_rdata = 32'hA5A5_A5A5;
        k = 0;
        busy_low = 0;
        got = 1'b0;
        while (k < 60 && !got) begin
            @(negedge clk);
            k++;
            if (!busy) busy_low++;
            if (wb_valid) got = 1'b1;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_data"}, wb_data, exp);
        check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        check({tag, "_en"}, {31'd0, wb_en}, {31'd0, rd != 5'd0});
        check({tag, "_busy"}, busy_low, 0);
    endtask

    task automatic count_wb(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wb_valid) n++;
        end
        check(tag, n, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_rs1 = '0;
        in_rd = '0;
        in_imm = '0;
        in_alu_control = '0;
        rf_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, in_ready}, 32'd1);

        run_op("addi", ALU_ADDI, 32'h0000_0005, 12'hFFF, 5'd3, 32'h0000_0004, 2);
        @(negedge clk);
        run_op("sltiu", ALU_SLTIU, 32'h0000_0001, 12'h800, 5'd4, 32'd1, 2);
        @(negedge clk);
        run_op("slti", ALU_SLTI, 32'h0000_0001, 12'h800, 5'd5, 32'd0, 2);
        @(negedge clk);
        run_op("srai", ALU_SRAI, 32'h8000_0000, 12'h404, 5'd6, 32'hF800_0000, 6);
        @(negedge clk);
        run_op("slli0", ALU_SLLI, 32'hDEAD_BEEF, 12'h000, 5'd0, 32'hDEAD_BEEF, 2);
        @(negedge clk);
        run_op("xori", ALU_XORI, 32'h0F0F_0F0F, 12'h0FF, 5'd7, 32'h0F0F_0FF0, 2);
        @(negedge clk);
        run_op("andi", ALU_ANDI, 32'h1234_5678, 12'h8F0, 5'd8, 32'h1234_5070, 2);
        @(negedge clk);
        run_op("slli3", ALU_SLLI, 32'h0000_0001, 12'h003, 5'd9, 32'h0000_0008, 5);
        @(negedge clk);
        run_op("srli31", ALU_SRLI, 32'h8000_0000, 12'h01F, 5'd10, 32'h0000_0001, 33);
        @(negedge clk);
        run_op("unk", 5'd31, 32'h0000_000A, 12'h7FF, 5'd11, 32'h0000_0809, 2);

        // ORI accepted in the ADDI's writeback cycle: second pulse two cycles later
        run_op("b2b_addi", ALU_ADDI, 32'h0000_0010, 12'h001, 5'd12, 32'h0000_0011, 2);
        run_op("b2b_ori", ALU_ORI, 32'h0000_0100, 12'h00F, 5'd13, 32'h0000_010F, 2);
        @(negedge clk);

        // Flush while shifting
        drive(ALU_SLLI, 32'h0000_0003, 12'h005, 5'd14);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("fl_shift_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_shift_busy", {31'd0, busy}, 32'd0);
        check("fl_shift_ready2", {31'd0, in_ready}, 32'd1);
        count_wb("fl_shift_nowb", 10);

        // Flush in the writeback cycle kills the pulse combinationally
        drive(ALU_ADDI, 32'h0000_0020, 12'h002, 5'd15);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("fl_wb_pre", {31'd0, wb_valid}, 32'd1);
        flush = 1'b1;
        #1;
        check("fl_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("fl_wb_en", {31'd0, wb_en}, 32'd0);
        check("fl_wb_data", wb_data, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_wb_busy", {31'd0, busy}, 32'd0);

        // Flush with in_valid in IDLE: no accept
        drive(ALU_ADDI, 32'h0000_0001, 12'h001, 5'd16);
        flush = 1'b1;
        #1;
        check("fl_idle_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_idle_busy", {31'd0, busy}, 32'd0);
        count_wb("fl_idle_nowb", 4);

        // Asynchronous reset in the middle of a shift
        drive(ALU_SRAI, 32'h8000_0000, 12'h008, 5'd17);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rs_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_wb("rs_nowb", 12);
        run_op("rs_addi", ALU_ADDI, 32'h0000_0100, 12'h023, 5'd18, 32'h0000_0123, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
